// File: rtl/nes_mem_arbiter.sv
// nes_mem_arbiter: shares one ROM/RAM port among flash loader, CPU and PPU.
// Boot sequencing, CPU/PPU round-robin and tagged fixed-latency read return.
module nes_mem_arbiter #(
  parameter int ADDR_W       = 22,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_done,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_qvalid,
  input  logic              ppu_req,
  input  logic [ADDR_W-1:0] ppu_addr,
  output logic              ppu_ack,
  output logic [DATA_W-1:0] ppu_q,
  output logic              ppu_qvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_DRAIN,
    S_RUN
  } state_t;

  state_t state;
  state_t state_nx;

  logic rr_ppu;
  logic gnt_ld;
  logic gnt_cpu;
  logic gnt_ppu;
  logic gnt_any;
  logic gnt_wr;
  logic iss_v;
  logic iss_p;
  logic [READ_LATENCY-1:0] tag_v;
  logic [READ_LATENCY-1:0] tag_p;
  logic pipe_busy;
  logic exit_cpu;
  logic exit_ppu;

  assign gnt_any   = gnt_ld | gnt_cpu | gnt_ppu;
  assign gnt_wr    = gnt_ld | (gnt_cpu & cpu_we);
  assign pipe_busy = iss_v | (|tag_v);
  assign exit_cpu  = tag_v[READ_LATENCY-1]
                   & ~tag_p[READ_LATENCY-1];
  assign exit_ppu  = tag_v[READ_LATENCY-1]
                   & tag_p[READ_LATENCY-1];

  // Boot state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_LOAD;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and the single winner of this clock.
  always_comb begin
    state_nx = state;
    gnt_ld   = 1'b0;
    gnt_cpu  = 1'b0;
    gnt_ppu  = 1'b0;
    unique case (state)
      S_LOAD: begin
        gnt_ld = ld_req;
        if (load_done) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (!pipe_busy) state_nx = S_RUN;
      end
      S_RUN: begin
        if (cpu_req && ppu_req) begin
          gnt_cpu = ~rr_ppu;
          gnt_ppu = rr_ppu;
        end else begin
          gnt_cpu = cpu_req;
          gnt_ppu = ppu_req;
        end
        if (!load_done) state_nx = S_LOAD;
      end
      default: state_nx = S_LOAD;
    endcase
  end

  // Registered issue: acks, memory strobes and the issue tag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ld_ack    <= 1'b0;
      cpu_ack   <= 1'b0;
      ppu_ack   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      iss_v     <= 1'b0;
      iss_p     <= 1'b0;
    end else begin
      ld_ack  <= gnt_ld;
      cpu_ack <= gnt_cpu;
      ppu_ack <= gnt_ppu;
      mem_we  <= gnt_wr;
      iss_v   <= gnt_ppu | (gnt_cpu & ~cpu_we);
      iss_p   <= gnt_ppu;
      if (gnt_any) begin
        unique case (1'b1)
          gnt_ld:  mem_addr <= ld_addr;
          gnt_cpu: mem_addr <= cpu_addr;
          gnt_ppu: mem_addr <= ppu_addr;
          default: mem_addr <= mem_addr;
        endcase
      end
      if (gnt_ld) begin
        mem_wdata <= ld_wdata;
      end else if (gnt_cpu && cpu_we) begin
        mem_wdata <= cpu_wdata;
      end
    end
  end

  // Round-robin pointer points away from the last granted port.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ppu <= 1'b0;
    end else if (gnt_cpu) begin
      rr_ppu <= 1'b1;
    end else if (gnt_ppu) begin
      rr_ppu <= 1'b0;
    end
  end

  // Tag pipe aligns each read's owner with its returning data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_v <= '0;
      tag_p <= '0;
    end else begin
      tag_v[0] <= iss_v;
      tag_p[0] <= iss_p;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_p[i] <= tag_p[i-1];
      end
    end
  end

  // Read data output registers with single-clock valid pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cpu_q      <= '0;
      cpu_qvalid <= 1'b0;
      ppu_q      <= '0;
      ppu_qvalid <= 1'b0;
    end else begin
      cpu_qvalid <= exit_cpu;
      ppu_qvalid <= exit_ppu;
      if (exit_cpu) cpu_q <= mem_rdata;
      if (exit_ppu) ppu_q <= mem_rdata;
    end
  end

endmodule
